// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin arbiter that shares one ULA between two requesters.
// A winner's operands are latched and launched, the ULA result (or a timeout
// abort) is returned to that requester with a one-cycle done pulse.
module ula_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  x0,
    input  logic [7:0]  x1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] c0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic [15:0] c1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err,
    output logic [15:0] result,
    output logic        busy,
    output logic [7:0]  ula_x,
    output logic [15:0] ula_a,
    output logic [15:0] ula_b,
    output logic [15:0] ula_c,
    output logic        ula_enable,
    output logic        ula_reset,
    input  logic        ula_ready,
    input  logic        ula_valid,
    input  logic [15:0] ula_result
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Last timer value before the abort fires; WAIT therefore lasts TIMEOUT cycles.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  timer_q, timer_d;
    logic        owner_q, owner_d;     // requester being served
    logic        last_q, last_d;       // requester served most recently
    logic        gnt0_q, gnt0_d;
    logic        gnt1_q, gnt1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        err_q, err_d;
    logic [15:0] result_q, result_d;
    logic        busy_q, busy_d;
    logic [7:0]  ula_x_q, ula_x_d;
    logic [15:0] ula_a_q, ula_a_d;
    logic [15:0] ula_b_q, ula_b_d;
    logic [15:0] ula_c_q, ula_c_d;
    logic        ula_enable_q, ula_enable_d;
    logic        ula_reset_q, ula_reset_d;

    logic        req_any;
    logic        win1;

    // Round-robin pick: a lone request always wins, a tie goes to the
    // requester that was not served last.
    always_comb begin
        req_any = req0 | req1;
        win1    = req1 & (~req0 | ~last_q);
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        owner_d      = owner_q;
        last_d       = last_q;
        result_d     = result_q;
        err_d        = err_q;
        ula_x_d      = ula_x_q;
        ula_a_d      = ula_a_q;
        ula_b_d      = ula_b_q;
        ula_c_d      = ula_c_q;
        // Strobes default low so each one is a single-cycle pulse.
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        ula_enable_d = 1'b0;
        ula_reset_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // ula_ready low simply holds off arbitration; requests stay pending.
                if (ula_ready && req_any) begin
                    state_d      = LAUNCH;
                    owner_d      = win1;
                    gnt0_d       = ~win1;
                    gnt1_d       = win1;
                    ula_enable_d = 1'b1;
                    ula_x_d      = win1 ? x1 : x0;
                    ula_a_d      = win1 ? a1 : a0;
                    ula_b_d      = win1 ? b1 : b0;
                    ula_c_d      = win1 ? c1 : c0;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
                timer_d = 8'd0;
            end
            WAIT: begin
                // A valid arriving on the expiry cycle still counts as success.
                if (ula_valid) begin
                    state_d  = RESP;
                    result_d = ula_result;
                    err_d    = 1'b0;
                    done0_d  = ~owner_q;
                    done1_d  = owner_q;
                end else if (timer_q == TIMER_LAST) begin
                    state_d     = RESP;
                    result_d    = 16'd0;
                    err_d       = 1'b1;
                    ula_reset_d = 1'b1;
                    done0_d     = ~owner_q;
                    done1_d     = owner_q;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset parks the ULA in reset and favours requester 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= 8'd0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            err_q        <= 1'b0;
            result_q     <= 16'd0;
            busy_q       <= 1'b0;
            ula_x_q      <= 8'd0;
            ula_a_q      <= 16'd0;
            ula_b_q      <= 16'd0;
            ula_c_q      <= 16'd0;
            ula_enable_q <= 1'b0;
            ula_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            owner_q      <= owner_d;
            last_q       <= last_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            err_q        <= err_d;
            result_q     <= result_d;
            busy_q       <= busy_d;
            ula_x_q      <= ula_x_d;
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_c_q      <= ula_c_d;
            ula_enable_q <= ula_enable_d;
            ula_reset_q  <= ula_reset_d;
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign err        = err_q;
    assign result     = result_q;
    assign busy       = busy_q;
    assign ula_x      = ula_x_q;
    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_c      = ula_c_q;
    assign ula_enable = ula_enable_q;
    assign ula_reset  = ula_reset_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// tb_ula_arbiter: randomized bench with a transaction-timeline reference model
// and a behavioural ULA that answers k cycles after enable (or never).
module tb_ula_arbiter;

    localparam int TMO = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  x0 = '0, x1 = '0;
    logic [15:0] a0 = '0, b0 = '0, c0 = '0, a1 = '0, b1 = '0, c1 = '0;
    logic        ula_ready = 1'b0, ula_valid = 1'b0;
    logic [15:0] ula_result = '0;
    logic        gnt0, gnt1, done0, done1, err, busy, ula_enable, ula_reset;
    logic [15:0] result, ula_a, ula_b, ula_c;
    logic [7:0]  ula_x;

    ula_arbiter #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .x0(x0), .x1(x1),
        .a0(a0), .b0(b0), .c0(c0), .a1(a1), .b1(b1), .c1(c1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err(err), .result(result), .busy(busy),
        .ula_x(ula_x), .ula_a(ula_a), .ula_b(ula_b), .ula_c(ula_c),
        .ula_enable(ula_enable), .ula_reset(ula_reset),
        .ula_ready(ula_ready), .ula_valid(ula_valid), .ula_result(ula_result)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0, cyc = 0;

    // Reference model: one transaction described by its launch/response cycles.
    bit          m_act = 0, m_own = 0, m_last = 1, m_err = 0, m_ehold = 0;
    int          m_launch = 0, m_resp = 0, m_k = 0, m_free = 0;
    logic [15:0] m_res = '0, m_rhold = '0, m_a = '0, m_b = '0, m_c = '0;
    logic [7:0]  m_x = '0;

    // Stimulus knobs
    int pr0 = 0, pr1 = 0, prdy = 100, kfix = 0, opmode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp_v, cyc);
    endtask

    function automatic logic [15:0] ula_fn(input logic [7:0] x, input logic [15:0] a,
                                           input logic [15:0] b, input logic [15:0] c);
        logic [15:0] xx;
        xx = {8'd0, x};
        return a * xx * xx + b * xx + c;
    endfunction

    task automatic chk_reset_vals(input string ph);
        chk({ph, "_gnt0"}, 32'(gnt0), 32'(0));
        chk({ph, "_gnt1"}, 32'(gnt1), 32'(0));
        chk({ph, "_done0"}, 32'(done0), 32'(0));
        chk({ph, "_done1"}, 32'(done1), 32'(0));
        chk({ph, "_err"}, 32'(err), 32'(0));
        chk({ph, "_busy"}, 32'(busy), 32'(0));
        chk({ph, "_en"}, 32'(ula_enable), 32'(0));
        chk({ph, "_ulareset"}, 32'(ula_reset), 32'(1));
        chk({ph, "_result"}, 32'(result), 32'(0));
        chk({ph, "_ulax"}, 32'(ula_x), 32'(0));
        chk({ph, "_ulaabc"}, 32'(ula_a | ula_b | ula_c), 32'(0));
    endtask

    // Assert reset mid-cycle, check the forced values at once, release on a falling edge.
    task automatic do_reset(input string ph);
        #2;
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; ula_valid = 1'b0;
        #1;
        chk_reset_vals(ph);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset_vals({ph, "_held"});
        reset = 1'b1;
        m_act = 0; m_last = 1; m_rhold = '0; m_ehold = 0; m_free = 0;
    endtask

    task automatic drive_ops();
        x0 = 8'($urandom); a0 = 16'($urandom); b0 = 16'($urandom); c0 = 16'($urandom);
        x1 = 8'($urandom); a1 = 16'($urandom); b1 = 16'($urandom); c1 = 16'($urandom);
        if (opmode == 1) begin
            x0 = 8'd3; a0 = 16'd3; b0 = 16'd3; c0 = 16'd3;
        end else if (opmode == 2) begin
            x0 = 8'd1; a0 = 16'd1; b0 = 16'd2; c0 = 16'd4;
            x1 = 8'd2; a1 = 16'd1; b1 = 16'd2; c1 = 16'd8;
        end
    endtask

    // One clock: update the model from inputs seen at this edge, compare, drive next inputs.
    task automatic step();
        bit l, r;
        @(posedge clock);
        cyc++;
        #1;
        if (!m_act && cyc >= m_free && ula_ready && (req0 || req1)) begin
            m_own    = (req0 && req1) ? ~m_last : req1;
            m_act    = 1;
            m_launch = cyc;
            m_x = m_own ? x1 : x0;
            m_a = m_own ? a1 : a0;
            m_b = m_own ? b1 : b0;
            m_c = m_own ? c1 : c0;
            m_k = (kfix > 0) ? kfix : $urandom_range(1, TMO + 2);
            m_err  = (m_k > TMO);
            m_res  = m_err ? 16'd0 : ula_fn(m_x, m_a, m_b, m_c);
            m_resp = m_err ? cyc + TMO + 1 : cyc + m_k + 1;
        end
        l = m_act && (cyc == m_launch);
        r = m_act && (cyc == m_resp);
        if (r) begin
            m_rhold = m_res;
            m_ehold = m_err;
        end
        chk("gnt0", 32'(gnt0), 32'(l && !m_own));
        chk("gnt1", 32'(gnt1), 32'(l && m_own));
        chk("ula_enable", 32'(ula_enable), 32'(l));
        chk("done0", 32'(done0), 32'(r && !m_own));
        chk("done1", 32'(done1), 32'(r && m_own));
        chk("ula_reset", 32'(ula_reset), 32'(r && m_err));
        chk("busy", 32'(busy), 32'(m_act));
        chk("result", 32'(result), 32'(m_rhold));
        chk("err", 32'(err), 32'(m_ehold));
        if (m_act) begin
            chk("ula_x", 32'(ula_x), 32'(m_x));
            chk("ula_a", 32'(ula_a), 32'(m_a));
            chk("ula_b", 32'(ula_b), 32'(m_b));
            chk("ula_c", 32'(ula_c), 32'(m_c));
        end
        if (r) begin
            m_act  = 0;
            m_last = m_own;
            m_free = cyc + 2;
        end
        // Behavioural ULA: answers once at launch+k while waiting, junk outside WAIT.
        if (m_act && cyc > m_launch) begin
            ula_valid  = (m_k <= TMO) && (cyc == m_launch + m_k);
            ula_result = ula_valid ? m_res : 16'($urandom);
        end else begin
            ula_valid  = ($urandom_range(0, 3) == 0);
            ula_result = 16'($urandom);
        end
        req0      = ($urandom_range(0, 99) < pr0);
        req1      = ($urandom_range(0, 99) < pr1);
        ula_ready = ($urandom_range(0, 99) < prdy);
        drive_ops();
    endtask

    task automatic drain();
        int n;
        pr0 = 0; pr1 = 0; prdy = 100;
        n = 0;
        while (m_act && n < 60) begin
            step();
            n++;
        end
        if (m_act) chk("drain_timeout", 32'(0), 32'(1));
        step();
    endtask

    initial begin
        int n;
        // Single requester, ULA answers three cycles after enable
        do_reset("rst0");
        opmode = 1; pr0 = 100; pr1 = 0; prdy = 100; kfix = 3;
        repeat (12) step();
        drain();

        // Contention from reset: alternate 0,1,0,1
        do_reset("rst1");
        opmode = 2; pr0 = 100; pr1 = 100; kfix = 2;
        repeat (40) step();
        drain();

        // Timeout, then normal completion
        opmode = 0; pr0 = 100; pr1 = 0; kfix = TMO + 10;
        repeat (TMO + 6) step();
        kfix = 2;
        repeat (40) step();
        drain();

        // Valid exactly on the expiry cycle
        pr0 = 100; pr1 = 100; kfix = TMO;
        repeat (40) step();
        drain();

        // ULA not ready stalls a pending request
        pr0 = 0; pr1 = 100; prdy = 0; kfix = 2;
        repeat (6) step();
        prdy = 100;
        repeat (10) step();
        drain();

        // Random traffic
        pr0 = 50; pr1 = 50; prdy = 80; kfix = 0;
        repeat (1500) step();

        // Reset in the middle of WAIT
        pr0 = 100; pr1 = 0; prdy = 100; kfix = TMO + 2;
        n = 0;
        while (!(m_act && cyc >= m_launch + 2) && n < 200) begin
            step();
            n++;
        end
        if (!(m_act && cyc >= m_launch + 2)) chk("reach_wait", 32'(0), 32'(1));
        pr0 = 0;
        do_reset("rst_mid");
        repeat (20) step();

        pr0 = 60; pr1 = 60; prdy = 85; kfix = 0;
        repeat (500) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
